if_fetch_queue: RTL and testbench

Parametrised instruction-fetch queue between the PC/instruction-bus side and the IF/ID pipeline register. It issues sequential fetch requests ahead of decode and tracks several in-flight bus requests. Returned instructions are buffered in order, each with its PC, in a DEPTH-entry circular queue. On a branch/jump redirect it flushes all buffered entries and silently discards responses that are still in flight. It replaces the single-instruction handoff from the fetch bus to IF/ID.

---
 rtl/if_fetch_queue.sv | 146 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction-fetch queue between the instruction bus and the IF/ID register.
//   Issues sequential fetch requests ahead of decode, keeps up to MAX_OUT bus
//   requests in flight and buffers returned instructions, each with its PC, in
//   a DEPTH-entry circular queue. A redirect flushes the queue and restarts
//   fetch; responses still owed for pre-redirect requests are discarded.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   redirect_ena/pc          flush and restart fetch at redirect_pc (word aligned)
//   req_valid/addr/ready     fetch request handshake towards the bus
//   resp_valid/inst          in-order instruction return from the bus
//   deq_valid/pc/inst/ready  head-of-queue handshake towards IF/ID
//   occupancy                allocated slots (awaiting response + filled)
module if_fetch_queue #(
  parameter int PC_W = 64,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_ena,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       req_valid,
  output logic [PC_W-1:0]            req_addr,
  input  logic                       req_ready,
  input  logic                       resp_valid,
  input  logic [INST_W-1:0]          resp_inst,
  output logic                       deq_valid,
  output logic [PC_W-1:0]            deq_pc,
  output logic [INST_W-1:0]          deq_inst,
  input  logic                       deq_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  alloc_cnt_q, alloc_cnt_d;
  // Filled-but-not-consumed entries; distinguishes a full queue of returned
  // instructions from an empty one when head == fill.
  logic [CNT_W-1:0]  ready_cnt_q, ready_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [PC_W-1:0]   slot_pc_q [DEPTH];
  logic [PC_W-1:0]   slot_pc_d [DEPTH];
  logic [INST_W-1:0] slot_inst_q [DEPTH];
  logic [INST_W-1:0] slot_inst_d [DEPTH];

  logic issue, resp_acc, resp_keep, deq_fire;

  assign req_valid = !redirect_ena && (alloc_cnt_q < DEPTH_C) && (out_cnt_q < MAX_OUT_C);
  assign req_addr  = fetch_pc_q;
  assign deq_valid = (ready_cnt_q != '0);
  assign deq_pc    = slot_pc_q[head_q];
  assign deq_inst  = slot_inst_q[head_q];
  assign occupancy = alloc_cnt_q;

  assign issue     = req_valid && req_ready;
  // A response with nothing outstanding is a bus protocol violation: ignore it.
  assign resp_acc  = resp_valid && (out_cnt_q != '0);
  assign resp_keep = resp_acc && (drop_cnt_q == '0) && !redirect_ena;
  assign deq_fire  = deq_valid && deq_ready && !redirect_ena;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_d      = fill_q;
    alloc_cnt_d = alloc_cnt_q;
    ready_cnt_d = ready_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    slot_pc_d   = slot_pc_q;
    slot_inst_d = slot_inst_q;
    // issue is impossible during a redirect, so this holds in both branches.
    out_cnt_d   = out_cnt_q + CNT_W'(issue) - CNT_W'(resp_acc);

    if (redirect_ena) begin
      head_d      = '0;
      tail_d      = '0;
      fill_d      = '0;
      alloc_cnt_d = '0;
      ready_cnt_d = '0;
      // Everything still owed by the bus belongs to the flushed stream.
      drop_cnt_d  = out_cnt_q - CNT_W'(resp_acc);
      fetch_pc_d  = redirect_pc & ~PC_W'(3);
    end else begin
      if (issue) begin
        slot_pc_d[tail_q] = fetch_pc_q;
        tail_d            = tail_q + PTR_W'(1);
        fetch_pc_d        = fetch_pc_q + PC_W'(4);
      end
      if (resp_acc && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (resp_keep) begin
        slot_inst_d[fill_q] = resp_inst;
        fill_d              = fill_q + PTR_W'(1);
      end
      if (deq_fire) begin
        head_d = head_q + PTR_W'(1);
      end
      alloc_cnt_d = alloc_cnt_q + CNT_W'(issue) - CNT_W'(deq_fire);
      ready_cnt_d = ready_cnt_q + CNT_W'(resp_keep) - CNT_W'(deq_fire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      alloc_cnt_q <= '0;
      ready_cnt_q <= '0;
      out_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]   <= '0;
        slot_inst_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      alloc_cnt_q <= alloc_cnt_d;
      ready_cnt_q <= ready_cnt_d;
      out_cnt_q   <= out_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]   <= slot_pc_d[i];
        slot_inst_q[i] <= slot_inst_d[i];
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue: randomized bus/consumer/redirect stimulus
// against a transaction-level reference. Requests are tagged with a fetch
// epoch that advances on every redirect; a response from an older epoch must
// vanish, and every surviving request must come out of the queue in issue
// order carrying the instruction the bus memory holds at its PC.
module tb_if_fetch_queue;
  localparam int PC_W = 64;
  localparam int INST_W = 32;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              redirect_ena;
  logic [PC_W-1:0]   redirect_pc;
  logic              req_valid;
  logic [PC_W-1:0]   req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic [INST_W-1:0] resp_inst;
  logic              deq_valid;
  logic [PC_W-1:0]   deq_pc;
  logic [INST_W-1:0] deq_inst;
  logic              deq_ready;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  if_fetch_queue #(
    .PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_ena(redirect_ena), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_inst(resp_inst),
    .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_inst(deq_inst), .deq_ready(deq_ready),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } bus_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  bus_t pend[$];   // requests the bus still owes a response for
  exp_t sb[$];     // expected dequeue stream since the last redirect

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] m_pc;
  int m_epoch, m_alloc, m_ready;
  bit exp_req_valid, exp_deq_valid;
  int exp_occ;
  logic [63:0] exp_addr;
  bit chk_en = 1'b0;

  int p_ready, p_deq, p_redir, p_junk, d_min, d_max;

  exp_t mon_e;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
  endfunction

  function automatic logic [63:0] pick_redirect();
    logic [63:0] r;
    case ($urandom_range(3, 0))
      0: r = 64'h8000_0102;
      1: r = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(3, 0));
      2: r = {32'h0, $urandom};
      default: r = 64'h8000_0100;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    m_pc = RESET_PC;
    m_alloc = 0;
    m_ready = 0;
    m_epoch = 0;
    pend.delete();
    sb.delete();
  endtask

  // Called just after a rising edge: drive inputs, publish this cycle's
  // expected outputs, then advance the reference to the next edge.
  task automatic body();
    bus_t b;
    exp_t e;
    bit resp_now, deq;
    redirect_ena = ($urandom_range(99, 0) < p_redir);
    redirect_pc  = pick_redirect();
    req_ready    = ($urandom_range(99, 0) < p_ready);
    deq_ready    = ($urandom_range(99, 0) < p_deq);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_inst  = mem_word(pend[0].addr);
    end else if (pend.size() == 0 && $urandom_range(99, 0) < p_junk) begin
      resp_valid = 1'b1;
      resp_inst  = 32'hDEAD_BEEF;
    end else begin
      resp_valid = 1'b0;
      resp_inst  = $urandom;
    end
    #1;
    exp_req_valid = !redirect_ena && (m_alloc < DEPTH) && (pend.size() < MAX_OUT);
    exp_addr      = m_pc;
    exp_occ       = m_alloc;
    exp_deq_valid = (m_ready > 0);

    resp_now = resp_valid && (pend.size() > 0);
    if (resp_now) begin
      b = pend.pop_front();
      if (b.epoch == m_epoch && !redirect_ena) m_ready++;
    end
    if (redirect_ena) begin
      m_epoch++;
      m_alloc = 0;
      m_ready = 0;
      sb.delete();
      m_pc = redirect_pc & ~64'h3;
    end else begin
      deq = exp_deq_valid && deq_ready;
      if (deq) begin
        m_alloc--;
        m_ready--;
      end
      if (exp_req_valid && req_ready) begin
        b.addr  = m_pc;
        b.epoch = m_epoch;
        b.due   = cyc + $urandom_range(d_max, d_min);
        pend.push_back(b);
        e.pc   = m_pc;
        e.inst = mem_word(m_pc);
        sb.push_back(e);
        m_alloc++;
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      body();
    end
  endtask

  task automatic set_knobs(input int r, input int d, input int rd, input int j,
                           input int dmin, input int dmax);
    p_ready = r; p_deq = d; p_redir = rd; p_junk = j; d_min = dmin; d_max = dmax;
  endtask

  // Monitor: compares DUT outputs mid-cycle and pops the scoreboard on every
  // dequeue handshake the DUT presents.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_valid", 64'(req_valid), 64'(exp_req_valid));
      if (exp_req_valid) chk("req_addr", req_addr, exp_addr);
      chk("occupancy", 64'(occupancy), 64'(exp_occ));
      chk("deq_valid", 64'(deq_valid), 64'(exp_deq_valid));
      if (deq_valid && deq_ready && !redirect_ena) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL deq_unexpected: got pc %h with nothing expected", deq_pc);
        end else begin
          mon_e = sb.pop_front();
          chk("deq_pc", deq_pc, mon_e.pc);
          chk("deq_inst", 64'(deq_inst), 64'(mon_e.inst));
          $display("deq pc=%h inst=%h", deq_pc, deq_inst);
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_req_valid"}, 64'(req_valid), 64'd1);
    chk({tag, "_req_addr"}, req_addr, RESET_PC);
    chk({tag, "_deq_valid"}, 64'(deq_valid), 64'd0);
    chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    chk({tag, "_deq_pc"}, deq_pc, 64'd0);
    chk({tag, "_deq_inst"}, 64'(deq_inst), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    redirect_ena = 1'b0;
    redirect_pc = '0;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_inst = '0;
    deq_ready = 1'b0;
    set_knobs(100, 100, 0, 0, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    reset_checks("reset");
    model_init();
    chk_en = 1'b1;
    body();

    // Streaming: bus always ready, one-cycle responses, consumer always ready.
    run(60);
    // Consumer stalled: queue fills to DEPTH, then single-cycle drains.
    set_knobs(100, 0, 0, 0, 1, 1);
    run(20);
    set_knobs(100, 30, 0, 0, 1, 1);
    run(60);
    // Slow bus: outstanding requests saturate at MAX_OUT.
    set_knobs(100, 100, 0, 0, 5, 5);
    run(100);
    // Mixed random traffic with redirects and stray responses.
    set_knobs(70, 60, 8, 10, 1, 4);
    run(1500);
    set_knobs(90, 90, 20, 5, 1, 2);
    run(800);

    // Reset in the middle of traffic clears everything at once.
    @(posedge clk);
    cyc++;
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    redirect_ena = 1'b0;
    resp_valid = 1'b0;
    #1;
    reset_checks("midreset");
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    model_init();
    chk_en = 1'b1;
    body();
    set_knobs(80, 70, 10, 5, 1, 6);
    run(800);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
